// File: rtl/fighter_pkg.sv
// fighter_pkg: shared state encodings, widths and meter arithmetic for the
// per-fighter controller.
package fighter_pkg;

    localparam int ACTION_W = 9;
    localparam int METER_W  = 8;

    localparam logic [7:0] ST_WALK   = 8'h01;
    localparam logic [7:0] ST_CROUCH = 8'h02;
    localparam logic [7:0] ST_SHIELD = 8'h04;
    localparam logic [7:0] ST_JUMP   = 8'h08;
    localparam logic [7:0] ST_PUNCH  = 8'h10;
    localparam logic [7:0] ST_STAND  = 8'h20;
    localparam logic [7:0] ST_STUN   = 8'h40;
    localparam logic [7:0] ST_KO     = 8'h80;

    typedef enum logic [7:0] {
        WALK   = ST_WALK,
        CROUCH = ST_CROUCH,
        SHIELD = ST_SHIELD,
        JUMP   = ST_JUMP,
        PUNCH  = ST_PUNCH,
        STAND  = ST_STAND,
        STUN   = ST_STUN,
        KO     = ST_KO
    } state_e;

    function automatic logic [METER_W-1:0] sat_sub(input logic [METER_W-1:0] a,
                                                   input logic [METER_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter stepped by frame ticks. done flags the
// final tick of an N-tick interval, half flags the first N/2 ticks.
module frame_timer #(
    parameter int N = 8,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         done,
    output logic         half
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = W'(N);
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == W'(1));
    // Counts N..(N - N/2 + 1) are the first N/2 ticks after a load.
    assign half  = (count_q > W'(N - N / 2));

endmodule

// File: rtl/fighter_ctrl.sv
// fighter_ctrl: per-fighter action FSM, X position, action timers and the
// health/shield meters, driven by debounced buttons and collision hits.
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int POS_W           = 10,
    parameter int X_MIN           = 16,
    parameter int X_MAX           = 608,
    parameter int START_X         = 320,
    parameter bit START_LEFT      = 1'b0,
    parameter int WALK_STEP       = 2,
    parameter int JUMP_FR         = 60,
    parameter int PUNCH_FR        = 8,
    parameter int COOLDOWN_FR     = 15,
    parameter int STUN_FR         = 20,
    parameter int MAX_HP          = 100,
    parameter int SHIELD_REGEN_FR = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                left_btn,
    input  logic                right_btn,
    input  logic                up_btn,
    input  logic                down_btn,
    input  logic                attack_btn,
    input  logic                shield_btn,
    input  logic                hit,
    input  logic [METER_W-1:0]  damage,
    output logic [POS_W-1:0]    x_pos,
    output logic [ACTION_W-1:0] action,
    output logic                attack_request,
    output logic                jump_rising,
    output logic [METER_W-1:0]  health,
    output logic [METER_W-1:0]  shield,
    output logic                ko
);

    localparam int JUMP_W  = $clog2(JUMP_FR + 1);
    localparam int PUNCH_W = $clog2(PUNCH_FR + 1);
    localparam int COOL_W  = $clog2(COOLDOWN_FR + 1);
    localparam int STUN_W  = $clog2(STUN_FR + 1);
    localparam int REGEN_W = $clog2(SHIELD_REGEN_FR + 1);

    localparam logic [POS_W-1:0]   X_LO       = POS_W'(X_MIN);
    localparam logic [POS_W-1:0]   X_HI       = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]   STEP       = POS_W'(WALK_STEP);
    localparam logic [POS_W-1:0]   X_LO_LIMIT = POS_W'(X_MIN + WALK_STEP);
    localparam logic [POS_W-1:0]   X_HI_LIMIT = POS_W'(X_MAX - WALK_STEP);
    localparam logic [METER_W-1:0] MAX_V      = METER_W'(MAX_HP);
    localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(SHIELD_REGEN_FR - 1);

    state_e               state_q, state_d, prio_state;
    logic                 facing_q, facing_d;
    logic [POS_W-1:0]     x_q, x_d;
    logic [METER_W-1:0]   health_q, health_d;
    logic [METER_W-1:0]   shield_q, shield_d;
    logic [REGEN_W-1:0]   regen_q, regen_d;
    logic                 attack_req_q, attack_req_d;

    logic                 jump_load, jump_clear, jump_done, jump_half;
    logic                 punch_load, punch_clear, punch_done;
    logic                 cool_load, cool_done, cool_ready;
    logic                 stun_load, stun_done;
    logic [COOL_W-1:0]    cool_count;
    logic [JUMP_W-1:0]    unused_jump_count;
    logic [PUNCH_W-1:0]   unused_punch_count;
    logic [STUN_W-1:0]    unused_stun_count;
    logic                 unused_punch_half, unused_cool_half, unused_stun_half;

    frame_timer #(.N(JUMP_FR), .W(JUMP_W)) u_jump_timer (
        .clk(clk), .reset(reset), .clear(jump_clear), .load(jump_load), .tick(frame_tick),
        .count(unused_jump_count), .done(jump_done), .half(jump_half)
    );

    frame_timer #(.N(PUNCH_FR), .W(PUNCH_W)) u_punch_timer (
        .clk(clk), .reset(reset), .clear(punch_clear), .load(punch_load), .tick(frame_tick),
        .count(unused_punch_count), .done(punch_done), .half(unused_punch_half)
    );

    frame_timer #(.N(COOLDOWN_FR), .W(COOL_W)) u_cool_timer (
        .clk(clk), .reset(reset), .clear(1'b0), .load(cool_load), .tick(frame_tick),
        .count(cool_count), .done(cool_done), .half(unused_cool_half)
    );

    frame_timer #(.N(STUN_FR), .W(STUN_W)) u_stun_timer (
        .clk(clk), .reset(reset), .clear(1'b0), .load(stun_load), .tick(frame_tick),
        .count(unused_stun_count), .done(stun_done), .half(unused_stun_half)
    );

    // Cooldown counts as expired on its final tick, so STAND lasts exactly COOLDOWN_FR ticks.
    assign cool_ready = (cool_count == '0) || cool_done;

    always_comb begin
        prio_state = STAND;
        if (down_btn) begin
            prio_state = CROUCH;
        end else if (shield_btn && (shield_q != '0)) begin
            prio_state = SHIELD;
        end else if (up_btn) begin
            prio_state = JUMP;
        end else if (attack_btn && cool_ready) begin
            prio_state = PUNCH;
        end else if (left_btn || right_btn) begin
            prio_state = WALK;
        end
    end

    always_comb begin
        state_d      = state_q;
        facing_d     = facing_q;
        x_d          = x_q;
        health_d     = health_q;
        shield_d     = shield_q;
        regen_d      = regen_q;
        attack_req_d = 1'b0;
        jump_load    = 1'b0;
        jump_clear   = 1'b0;
        punch_load   = 1'b0;
        punch_clear  = 1'b0;
        cool_load    = 1'b0;
        stun_load    = 1'b0;

        if (state_q != KO) begin
            if (hit) begin
                if (state_q == SHIELD) begin
                    shield_d = sat_sub(shield_q, damage);
                    health_d = sat_sub(health_q, (damage > shield_q) ? damage - shield_q : '0);
                end else begin
                    health_d = sat_sub(health_q, damage);
                end
                jump_clear  = 1'b1;
                punch_clear = 1'b1;
                if (health_d == '0) begin
                    state_d = KO;
                end else begin
                    state_d   = STUN;
                    stun_load = 1'b1;
                end
            end else if (frame_tick) begin
                case (state_q)
                    STUN:    if (stun_done)  state_d = STAND;
                    PUNCH:   if (punch_done) state_d = STAND;
                    JUMP:    if (jump_done)  state_d = prio_state;
                    default: begin
                        state_d = prio_state;
                        if (state_q != SHIELD) begin
                            if (right_btn) begin
                                facing_d = 1'b0;
                            end else if (left_btn) begin
                                facing_d = 1'b1;
                            end
                        end
                    end
                endcase

                // Airborne steering moves the fighter without turning it around.
                if ((state_d == WALK) || ((state_q == JUMP) && (state_d == JUMP))) begin
                    if (right_btn) begin
                        x_d = (x_q > X_HI_LIMIT) ? X_HI : x_q + STEP;
                    end else if (left_btn) begin
                        x_d = (x_q < X_LO_LIMIT) ? X_LO : x_q - STEP;
                    end
                end

                jump_load    = (state_d == JUMP) && ((state_q != JUMP) || jump_done);
                punch_load   = (state_d == PUNCH) && (state_q != PUNCH);
                attack_req_d = punch_load;
            end

            cool_load = (state_q == PUNCH) && (state_d != PUNCH);

            // Regen progress restarts whenever a tick is spent holding the shield up.
            if (frame_tick && (state_q == SHIELD)) begin
                regen_d = '0;
            end else if (frame_tick) begin
                if (regen_q >= REGEN_LAST) begin
                    regen_d = '0;
                    if (shield_q < MAX_V) begin
                        shield_d = shield_q + METER_W'(1);
                    end
                end else begin
                    regen_d = regen_q + REGEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= STAND;
            facing_q     <= START_LEFT;
            x_q          <= POS_W'(START_X);
            health_q     <= MAX_V;
            shield_q     <= MAX_V;
            regen_q      <= '0;
            attack_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            facing_q     <= facing_d;
            x_q          <= x_d;
            health_q     <= health_d;
            shield_q     <= shield_d;
            regen_q      <= regen_d;
            attack_req_q <= attack_req_d;
        end
    end

    assign x_pos          = x_q;
    assign action         = {facing_q, state_q};
    assign attack_request = attack_req_q;
    assign jump_rising    = (state_q == JUMP) && jump_half;
    assign health         = health_q;
    assign shield         = shield_q;
    assign ko             = (state_q == KO);

endmodule

// File: tb/tb_fighter_ctrl.sv
// tb_fighter_ctrl: directed scoreboard bench for fighter_ctrl with default parameters.
module tb_fighter_ctrl;

    localparam logic [7:0] S_WALK   = 8'h01;
    localparam logic [7:0] S_SHIELD = 8'h04;
    localparam logic [7:0] S_JUMP   = 8'h08;
    localparam logic [7:0] S_PUNCH  = 8'h10;
    localparam logic [7:0] S_STAND  = 8'h20;
    localparam logic [7:0] S_STUN   = 8'h40;
    localparam logic [7:0] S_KO     = 8'h80;

    logic       clk = 1'b0;
    logic       reset, frame_tick, hit;
    logic       left_btn, right_btn, up_btn, down_btn, attack_btn, shield_btn;
    logic [7:0] damage;
    logic [9:0] x_pos;
    logic [8:0] action;
    logic       attack_request, jump_rising, ko;
    logic [7:0] health, shield;

    typedef struct packed {
        logic [8:0] expAction;
        logic [9:0] expX;
        logic [7:0] expHp;
        logic [7:0] expSh;
        logic       expAr;
        logic       expJr;
        logic       expKo;
    } exp_t;

    exp_t  sb[$];
    string tagQ[$];
    int    nAsserts = 0;
    int    nFail    = 0;

    logic [7:0] eSt;
    logic       eFace, eAr, eJr;
    int         eX, eHp, eSh;

    always #5 clk = ~clk;

    fighter_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .left_btn(left_btn), .right_btn(right_btn), .up_btn(up_btn), .down_btn(down_btn),
        .attack_btn(attack_btn), .shield_btn(shield_btn), .hit(hit), .damage(damage),
        .x_pos(x_pos), .action(action), .attack_request(attack_request),
        .jump_rising(jump_rising), .health(health), .shield(shield), .ko(ko)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExpect(input string tag);
        exp_t e;
        e.expAction = {eFace, eSt};
        e.expX      = 10'(eX);
        e.expHp     = 8'(eHp);
        e.expSh     = 8'(eSh);
        e.expAr     = eAr;
        e.expJr     = eJr;
        e.expKo     = (eSt == S_KO);
        sb.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic chk(input string tag, input string field, input logic [15:0] obs,
                       input logic [15:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFail++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            nAsserts++;
            nFail++;
            $display("[TB] FAIL scoreboard: no expectation queued");
            return;
        end
        e = sb.pop_front();
        t = tagQ.pop_front();
        chk(t, "action", 16'(action), 16'(e.expAction));
        chk(t, "x_pos", 16'(x_pos), 16'(e.expX));
        chk(t, "health", 16'(health), 16'(e.expHp));
        chk(t, "shield", 16'(shield), 16'(e.expSh));
        chk(t, "attack_request", 16'(attack_request), 16'(e.expAr));
        chk(t, "jump_rising", 16'(jump_rising), 16'(e.expJr));
        chk(t, "ko", 16'(ko), 16'(e.expKo));
    endtask

    task automatic applyStimulus(input string tag, input logic tk, input logic hh,
                                 input logic [7:0] dmg);
        @(negedge clk);
        frame_tick = tk;
        hit        = hh;
        damage     = dmg;
        pushExpect(tag);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit        = 1'b0;
        damage     = 8'd0;
        checkOutput();
    endtask

    task automatic tick(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic hitOnly(input string tag, input logic [7:0] dmg);
        applyStimulus(tag, 1'b0, 1'b1, dmg);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        eSt = S_STAND; eFace = 1'b0; eX = 320; eHp = 100; eSh = 100; eAr = 1'b0; eJr = 1'b0;
        pushExpect(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput();
    endtask

    initial begin
        reset = 1'b0; frame_tick = 1'b0; hit = 1'b0; damage = 8'd0;
        left_btn = 1'b0; right_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
        attack_btn = 1'b0; shield_btn = 1'b0;
        repeat (2) @(posedge clk);

        // Walking right, then left into the X_MIN clamp.
        doReset("reset");
        right_btn = 1'b1; eSt = S_WALK; eFace = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            eX = 320 + 2 * k;
            tick("walk_right");
        end
        right_btn = 1'b0; left_btn = 1'b1; eFace = 1'b1;
        while (eX > 18) begin
            eX -= 2;
            tick("walk_left");
        end
        for (int k = 0; k < 5; k++) begin
            eX = (eX - 2 < 16) ? 16 : eX - 2;
            tick("walk_left_sat");
        end
        left_btn = 1'b0; eSt = S_STAND;
        tick("walk_stop");

        // Jump: 60 ticks, rising for the first 30, attack ignored, steering keeps facing.
        up_btn = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            if (j == 2) up_btn = 1'b0;
            attack_btn = (j >= 20 && j <= 25);
            right_btn  = (j >= 40 && j <= 42);
            if (right_btn) eX += 2;
            eSt = S_JUMP;
            eJr = (j <= 30);
            tick("jump");
        end
        right_btn = 1'b0; attack_btn = 1'b0; eSt = S_STAND; eJr = 1'b0;
        tick("jump_end");

        // Held attack: punch 8 ticks, stand 15 ticks, then punch again.
        attack_btn = 1'b1; eSt = S_PUNCH; eAr = 1'b1;
        tick("punch1_start");
        eAr = 1'b0;
        applyStimulus("punch1_pulse_low", 1'b0, 1'b0, 8'd0);
        for (int p = 2; p <= 8; p++) tick("punch1");
        eSt = S_STAND;
        tick("punch1_exit");
        for (int s = 1; s <= 14; s++) tick("cooldown");
        eSt = S_PUNCH; eAr = 1'b1;
        tick("punch2_start");
        attack_btn = 1'b0; eAr = 1'b0;
        for (int p = 2; p <= 8; p++) tick("punch2");
        eSt = S_STAND;
        tick("punch2_exit");

        // Shield absorbs damage first, overflow reaches health, regen resumes outside SHIELD.
        doReset("reset_shield");
        shield_btn = 1'b1; eSt = S_SHIELD;
        tick("shield_enter");
        eSt = S_STUN; eSh = 10;
        hitOnly("shield_hit90", 8'd90);
        for (int t = 1; t <= 20; t++) begin
            if (t == 20) eSt = S_STAND;
            tick("stun1");
        end
        eSt = S_SHIELD;
        tick("shield_reenter");
        eSt = S_STUN; eSh = 0; eHp = 85;
        hitOnly("shield_hit25", 8'd25);
        shield_btn = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 8) eSh = 1;
            if (t == 20) eSt = S_STAND;
            tick("stun2");
        end

        // Knockout during a jump, then inputs are dead until reset.
        doReset("reset_ko");
        eSt = S_STUN; eHp = 5;
        hitOnly("hit95", 8'd95);
        for (int t = 1; t <= 20; t++) begin
            if (t == 20) eSt = S_STAND;
            tick("stun3");
        end
        up_btn = 1'b1; eSt = S_JUMP; eJr = 1'b1;
        tick("ko_jump_start");
        up_btn = 1'b0;
        tick("ko_jump");
        eSt = S_KO; eHp = 0; eJr = 1'b0;
        hitOnly("ko_hit9", 8'd9);
        {left_btn, right_btn, up_btn, down_btn, attack_btn, shield_btn} = 6'b111111;
        for (int k = 0; k < 5; k++) tick("ko_frozen");
        hitOnly("ko_hit_again", 8'd5);
        {left_btn, right_btn, up_btn, down_btn, attack_btn, shield_btn} = 6'b000000;
        doReset("reset_from_ko");

        // Hit coinciding with a tick beats the held up button; a hit in STUN reloads it.
        up_btn = 1'b1; eSt = S_STUN; eHp = 90;
        applyStimulus("hit_and_tick", 1'b1, 1'b1, 8'd10);
        for (int t = 1; t <= 10; t++) tick("stun4");
        eHp = 89;
        hitOnly("stun_reload", 8'd1);
        for (int t = 1; t <= 20; t++) begin
            if (t == 20) eSt = S_STAND;
            tick("stun5");
        end
        eSt = S_JUMP; eJr = 1'b1;
        tick("jump_after_stun");
        tick("jump_tick2");
        up_btn = 1'b0;
        doReset("reset_mid_jump");
        eSt = S_STAND;
        tick("idle_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
